// File: rtl/sq16_pkg.sv
// Shared definitions for the sq16 root checker: default width, FSM encoding
// and the iteration-counter width helper.
package sq16_pkg;

  localparam int WIDTH_DEF = 16;

  // Counter must reach WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sq16_mul_core.sv
// Iterative shift-add multiplier: one multiplier bit per step, LSB first.
// Operands are latched on load; acc_next exposes the accumulator value being written this edge.
module sq16_mul_core
  import sq16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               done
);

  localparam int CW = cnt_width(WIDTH);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] partial;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      bit_idx;

  assign bit_idx = cnt_q[IW-1:0];
  assign partial = {{WIDTH{1'b0}}, a_q} << cnt_q;

  always_comb begin
    acc_d = acc_q;
    if (step && b_q[bit_idx]) begin
      acc_d = acc_q + partial;
    end
  end

  // The final step coincides with the last multiplier bit.
  assign done     = step && (cnt_q == CW'(WIDTH - 1));
  assign acc_next = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/sq16_check.sv
// Integer square-root checker: squares a candidate root over WIDTH cycles and
// reports whether it is the exact and/or floor root of the given radicand.
//
// state   | meaning
// IDLE    | no result held
// BUSY    | shift-add iterations in progress
// DONE    | result held until next accepted start or reset
module sq16_check
  import sq16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   root,
  input  logic [2*WIDTH-1:0] target,
  output logic               rdy,
  output logic [2*WIDTH-1:0] square,
  output logic               exact,
  output logic               floor_ok,
  output logic               busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   root_q;
  logic [2*WIDTH-1:0] target_q;
  logic [2*WIDTH-1:0] square_q, square_d;
  logic               exact_q, exact_d;
  logic               floor_q, floor_d;

  logic               accept;
  logic               step;
  logic               core_done;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH:0]   upper;
  logic               exact_calc;
  logic               floor_calc;

  assign accept = start && (state_q != ST_BUSY);
  assign step   = (state_q == ST_BUSY);

  sq16_mul_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .a        (root),
    .b        (root),
    .acc_next (acc_next),
    .done     (core_done)
  );

  // (root+1)^2 = root^2 + 2*root + 1, kept one bit wider so root=all-ones cannot wrap.
  assign upper = {1'b0, acc_next}
               + {{WIDTH{1'b0}}, root_q, 1'b0}
               + (2*WIDTH+1)'(1);

  assign exact_calc = (acc_next == target_q);
  assign floor_calc = (acc_next <= target_q) && ({1'b0, target_q} < upper);

  always_comb begin
    state_d  = state_q;
    square_d = square_q;
    exact_d  = exact_q;
    floor_d  = floor_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_BUSY;
          square_d = '0;
          exact_d  = 1'b0;
          floor_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d  = ST_DONE;
          square_d = acc_next;
          exact_d  = exact_calc;
          floor_d  = floor_calc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      root_q   <= '0;
      target_q <= '0;
      square_q <= '0;
      exact_q  <= 1'b0;
      floor_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      square_q <= square_d;
      exact_q  <= exact_d;
      floor_q  <= floor_d;
      if (accept) begin
        root_q   <= root;
        target_q <= target;
      end
    end
  end

  assign rdy      = (state_q == ST_DONE);
  assign busy     = (state_q == ST_BUSY);
  assign square   = square_q;
  assign exact    = exact_q;
  assign floor_ok = floor_q;

endmodule

// File: tb/tb_sq16_check.sv
// Directed bench for sq16_check: hand-computed squares and root verdicts,
// latency, start handshaking and reset behaviour.
module tb_sq16_check;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] root;
  logic [31:0] target;
  logic        rdy;
  logic [31:0] square;
  logic        exact;
  logic        floor_ok;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  sq16_check #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .root     (root),
    .target   (target),
    .rdy      (rdy),
    .square   (square),
    .exact    (exact),
    .floor_ok (floor_ok),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then scramble the operands and wait for rdy.
  // cyc = number of edges after the start edge at which rdy was seen (99 = timeout).
  task automatic do_op(input logic [15:0] r, input logic [31:0] t, output int cyc);
    @(negedge clk);
    start  = 1'b1;
    root   = r;
    target = t;
    @(negedge clk);
    start  = 1'b0;
    root   = ~r;
    target = ~t;
    cyc = 0;
    while (!rdy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!rdy) cyc = 99;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    root = 16'd9;
    target = 32'd81;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({rdy, busy, exact, floor_ok} !== 4'b0000 || square !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy/busy/exact/floor=%b square=%h, want 0000 / 0",
               {rdy, busy, exact, floor_ok}, square);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: got rdy/busy=%b want 00", {rdy, busy});
    end
  endtask

  task automatic test_exact;
    int cyc;
    do_op(16'd4, 32'd16, cyc);
    n_cmp++;
    if (cyc !== 16) begin
      n_bad++;
      $display("FAIL exact_latency: got %0d want 16", cyc);
    end
    n_cmp++;
    if (square !== 32'd16 || exact !== 1'b1 || floor_ok !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL exact_4: got sq=%0d ex=%b fl=%b busy=%b want 16 1 1 0",
               square, exact, floor_ok, busy);
    end
  endtask

  task automatic test_floor;
    int cyc;
    do_op(16'd3, 32'd10, cyc);
    n_cmp++;
    if (cyc !== 16 || square !== 32'd9 || exact !== 1'b0 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL floor_3_10: got cyc=%0d sq=%0d ex=%b fl=%b want 16 9 0 1",
               cyc, square, exact, floor_ok);
    end
    do_op(16'd5, 32'd24, cyc);
    n_cmp++;
    if (cyc !== 16 || square !== 32'd25 || exact !== 1'b0 || floor_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL floor_5_24: got cyc=%0d sq=%0d ex=%b fl=%b want 16 25 0 0",
               cyc, square, exact, floor_ok);
    end
    do_op(16'd4, 32'd24, cyc);
    n_cmp++;
    if (square !== 32'd16 || exact !== 1'b0 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL floor_4_24: got sq=%0d ex=%b fl=%b want 16 0 1", square, exact, floor_ok);
    end
    do_op(16'd4, 32'd25, cyc);
    n_cmp++;
    if (square !== 32'd16 || exact !== 1'b0 || floor_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL floor_4_25: got sq=%0d ex=%b fl=%b want 16 0 0", square, exact, floor_ok);
    end
  endtask

  task automatic test_upper;
    int cyc;
    do_op(16'hFFFF, 32'hFFFFFFFF, cyc);
    n_cmp++;
    if (square !== 32'hFFFE0001 || exact !== 1'b0 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL upper_max: got sq=%h ex=%b fl=%b want fffe0001 0 1", square, exact, floor_ok);
    end
    do_op(16'hFFFF, 32'hFFFE0000, cyc);
    n_cmp++;
    if (square !== 32'hFFFE0001 || exact !== 1'b0 || floor_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL upper_below: got sq=%h ex=%b fl=%b want fffe0001 0 0", square, exact, floor_ok);
    end
    do_op(16'hFFFF, 32'hFFFE0001, cyc);
    n_cmp++;
    if (exact !== 1'b1 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL upper_exact: got ex=%b fl=%b want 1 1", exact, floor_ok);
    end
  endtask

  task automatic test_handshake;
    int cyc;
    @(negedge clk);
    start = 1'b1; root = 16'd7; target = 32'd49;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        start = 1'b1; root = 16'd2; target = 32'd4;
      end else begin
        start = 1'b0;
      end
    end
    n_cmp++;
    if (cyc !== 16 || square !== 32'd49 || exact !== 1'b1 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got cyc=%0d sq=%0d ex=%b fl=%b want 16 49 1 1",
               cyc, square, exact, floor_ok);
    end
    // Restart from DONE: rdy and results clear on the accepting edge.
    start = 1'b1; root = 16'd0; target = 32'd0;
    @(negedge clk);
    start = 1'b0; root = 16'd3; target = 32'd9;
    n_cmp++;
    if (rdy !== 1'b0 || busy !== 1'b1 || square !== 32'd0 || exact !== 1'b0 || floor_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL done_restart: got rdy=%b busy=%b sq=%h ex=%b fl=%b want 0 1 0 0 0",
               rdy, busy, square, exact, floor_ok);
    end
    cyc = 0;
    while (!rdy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 16 || square !== 32'd0 || exact !== 1'b1 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL root_zero: got cyc=%0d sq=%0d ex=%b fl=%b want 16 0 1 1",
               cyc, square, exact, floor_ok);
    end
    // Result holds while idle in DONE.
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b1 || square !== 32'd0 || exact !== 1'b1) begin
      n_bad++;
      $display("FAIL done_hold: got rdy=%b sq=%0d ex=%b want 1 0 1", rdy, square, exact);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    start = 1'b1; root = 16'd100; target = 32'd10000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1; start = 1'b1; root = 16'd5; target = 32'd25;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_cmp++;
    if (rdy !== 1'b0 || busy !== 1'b0 || square !== 32'd0 || exact !== 1'b0 || floor_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got rdy=%b busy=%b sq=%h ex=%b fl=%b want 0 0 0 0 0",
               rdy, busy, square, exact, floor_ok);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_queue: got rdy=%b busy=%b want 0 0", rdy, busy);
    end
    do_op(16'd100, 32'd10000, cyc);
    n_cmp++;
    if (cyc !== 16 || square !== 32'd10000 || exact !== 1'b1 || floor_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset: got cyc=%0d sq=%0d ex=%b fl=%b want 16 10000 1 1",
               cyc, square, exact, floor_ok);
    end
  endtask

  task automatic test_cross;
    logic [31:0] xs [8];
    logic [15:0] ys [8];
    logic [31:0] sq_exp;
    int cyc;
    xs = '{32'd0, 32'd1, 32'd2, 32'd15, 32'd16, 32'd17, 32'd65535, 32'hFFFFFFFF};
    ys = '{16'd0, 16'd1, 16'd1, 16'd3, 16'd4, 16'd4, 16'd255, 16'hFFFF};
    for (int i = 0; i < 8; i++) begin
      do_op(ys[i], xs[i], cyc);
      sq_exp = 32'(ys[i]) * 32'(ys[i]);
      n_cmp++;
      if (cyc !== 16 || floor_ok !== 1'b1 || square !== sq_exp || exact !== (sq_exp == xs[i])) begin
        n_bad++;
        $display("FAIL cross_%0d: x=%h y=%h got cyc=%0d sq=%h ex=%b fl=%b want 16 %h %b 1",
                 i, xs[i], ys[i], cyc, square, exact, floor_ok, sq_exp, (sq_exp == xs[i]));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    root = '0;
    target = '0;
    test_reset();
    test_exact();
    test_floor();
    test_upper();
    test_handshake();
    test_reset_mid();
    test_cross();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sq16_check.md
Name: sq16_check

Overview:
- Sequential integer-square-root result checker and squarer.
- Takes a 16-bit candidate root and the 32-bit radicand it was computed from, squares the root with an iterative shift-add datapath, and reports whether the root is the exact or floor square root.
- Used as the self-check responder beside the sqrt32 unit: sqrt32 produces y from x, and this block verifies y against x in hardware.
- Also usable as a standalone squarer.

Parameters:
- WIDTH, 16, root width. Radicand and square are 2*WIDTH bits; the internal (root+1)^2 is 2*WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; operands are sampled on the same edge
- root  input  WIDTH  candidate square root
- target  input  2*WIDTH  radicand the root was derived from
- rdy  output  1  result valid; held until the next accepted start or reset
- square  output  2*WIDTH  root*root
- exact  output  1  square == target
- floor_ok  output  1  root^2 <= target < (root+1)^2
- busy  output  1  computation in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset, sampled on the rising edge of clk.
- Reset values: rdy=0, busy=0, square=0, exact=0, floor_ok=0, state=IDLE, all internal registers 0.
- States:
  - IDLE: no result held.
  - BUSY: iterating.
  - DONE: result held.
- IDLE/DONE, start=1 sampled:
  - Latch root and target into internal registers.
  - Clear the accumulator and set count=0.
  - Go to BUSY: busy=1, rdy=0.
  - square, exact and floor_ok go to 0 on that same edge.
- BUSY, each edge:
  - Examine bit `count` of the latched root; if set, add (root << count) to the 2*WIDTH accumulator.
  - count increments.
  - After WIDTH iterations, go to DONE.
- Latency: start sampled at edge t0; the iterations occupy edges t0+1 .. t0+WIDTH. At edge t0+WIDTH: state=DONE, busy=0, rdy=1, and square, exact, floor_ok are valid. WIDTH=16 gives 16 cycles start-to-rdy.
- Result computation, registered on the DONE-entry edge from the final accumulator value:
  - exact = (acc == target).
  - upper = acc + 2*root + 1, computed at 2*WIDTH+1 bits with no truncation. For root=2^WIDTH-1, upper = 2^(2*WIDTH).
  - floor_ok = (acc <= target) && (target < upper).
- Width rules:
  - The accumulator never overflows, since max square = (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - All comparisons are unsigned.
- start while BUSY: ignored. Operands, count and outputs are unaffected, and no request is queued.
- start in DONE: accepted exactly as from IDLE; rdy falls on the same edge.
- root/target changing after the start edge: no effect on the result (latched copies only).
- reset during BUSY or DONE: IDLE on that edge, all outputs at reset values, the in-flight result is discarded. Reset has priority over a simultaneous start.
- root=0: still takes WIDTH cycles; square=0; exact=(target==0); floor_ok=(target==0).

Decomposition:
- Shared package sq16_pkg:
  - WIDTH default
  - state encoding IDLE/BUSY/DONE
  - counter width clog2(WIDTH)+1
- One natural sub-module, sq16_mul_core:
  - Iterative shift-add multiplier: latched operand, accumulator, counter, done pulse.
  - Reusable for a general a*b later.
- sq16_check is the top level: FSM plus the compare logic.

Test Plan:
- Exact root: reset 2 cycles, start with root=4, target=16 -> after 16 cycles rdy=1, square=16, exact=1, floor_ok=1.
- Floor root: root=3, target=10 -> square=9, exact=0, floor_ok=1. root=5, target=24 -> square=25, exact=0, floor_ok=0.
- Upper boundary: root=16'hFFFF, target=32'hFFFFFFFF -> square=32'hFFFE0001, exact=0, floor_ok=1 (upper=2^32, no wrap). root=16'hFFFF, target=32'hFFFE0000 -> floor_ok=0.
- Handshake:
  - start root=7, target=49; pulse start again at cycle 5 with root=2 -> ignored; at cycle 16 square=49, exact=1.
  - Then start root=0, target=0 in DONE -> rdy drops the same edge; 16 cycles later square=0, exact=1, floor_ok=1.
- Reset mid-operation: start root=100, target=10000; assert reset at cycle 8 together with start -> IDLE, rdy=0, busy=0, square=0. A new start after reset gives square=10000 at +16 cycles.
- Cross-check loop: drive sqrt32 with x in {0, 1, 2, 15, 16, 17, 65535, 32'hFFFFFFFF}; feed each y and x to sq16_check -> floor_ok=1 for every case.
